// File: rtl/counter_ud_pkg.sv
// rtl/counter_ud_pkg.sv - shared constants, raw width helper and flag priority enum for counter_ud_param
package counter_ud_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Two extra bits hold one step of overshoot above the ceiling and a sign bit below zero.
  function automatic int raw_width(input int width);
    return width + 2;
  endfunction

  typedef enum logic [2:0] {
    FLAG_RESET,
    FLAG_REINIT,
    FLAG_EVENT,
    FLAG_CLEAR,
    FLAG_HOLD
  } flag_prio_e;

endpackage

// File: rtl/counter_ud_next.sv
// rtl/counter_ud_next.sv - combinational next count: raw sum, wrap/saturate select, limit events
module counter_ud_next
  import counter_ud_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int INCR_WIDTH = 2,
  parameter int DECR_WIDTH = 2,
  parameter int MAX_VALUE  = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0]      value,
  input  logic                  reinit,
  input  logic [WIDTH-1:0]      initial_value,
  input  logic                  incr_valid,
  input  logic [INCR_WIDTH-1:0] incr,
  input  logic                  decr_valid,
  input  logic [DECR_WIDTH-1:0] decr,
  input  logic                  sat_en,
  output logic [WIDTH-1:0]      value_next,
  output logic [WIDTH-1:0]      limit,
  output logic                  ovf_event,
  output logic                  unf_event
);

  localparam int RAW_W = raw_width(WIDTH);

  logic [RAW_W-1:0]        add;
  logic [RAW_W-1:0]        sub;
  logic signed [RAW_W-1:0] raw;
  logic signed [RAW_W-1:0] limit_s;

  assign limit   = (sat_en == MODE_SAT) ? WIDTH'(MAX_VALUE) : {WIDTH{1'b1}};
  assign add     = incr_valid ? RAW_W'(incr) : '0;
  assign sub     = decr_valid ? RAW_W'(decr) : '0;
  assign raw     = $signed(RAW_W'(value) + add - sub);
  assign limit_s = $signed(RAW_W'(limit));

  assign ovf_event = raw > limit_s;
  assign unf_event = raw[RAW_W-1];

  // Wrap mode simply drops the upper bits of raw.
  always_comb begin
    value_next = raw[WIDTH-1:0];
    if (reinit) begin
      value_next = initial_value;
    end else if (sat_en == MODE_SAT) begin
      if (ovf_event) begin
        value_next = limit;
      end else if (unf_event) begin
        value_next = '0;
      end
    end
  end

endmodule

// File: rtl/counter_ud_param.sv
// rtl/counter_ud_param.sv - parametrised up/down counter with wrap/saturate modes and sticky limit flags
module counter_ud_param
  import counter_ud_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INCR_WIDTH  = 2,
  parameter int DECR_WIDTH  = 2,
  parameter int MAX_VALUE   = 2**WIDTH-1,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reinit,
  input  logic [WIDTH-1:0]      initial_value,
  input  logic                  incr_valid,
  input  logic [INCR_WIDTH-1:0] incr,
  input  logic                  decr_valid,
  input  logic [DECR_WIDTH-1:0] decr,
  input  logic                  sat_en,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      value,
  output logic [WIDTH-1:0]      value_next,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  at_max,
  output logic                  at_zero
);

  logic [WIDTH-1:0] limit;
  logic             ovf_event;
  logic             unf_event;

  counter_ud_next #(
    .WIDTH     (WIDTH),
    .INCR_WIDTH(INCR_WIDTH),
    .DECR_WIDTH(DECR_WIDTH),
    .MAX_VALUE (MAX_VALUE)
  ) u_next (
    .value        (value),
    .reinit       (reinit),
    .initial_value(initial_value),
    .incr_valid   (incr_valid),
    .incr         (incr),
    .decr_valid   (decr_valid),
    .decr         (decr),
    .sat_en       (sat_en),
    .value_next   (value_next),
    .limit        (limit),
    .ovf_event    (ovf_event),
    .unf_event    (unf_event)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= WIDTH'(RESET_VALUE);
    end else begin
      value <= value_next;
    end
  end

  // An event wins over clear_flags so a same-cycle limit hit is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (reinit) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (unf_event) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

  assign at_max  = value == limit;
  assign at_zero = value == '0;

endmodule
